csr_file: RTL and testbench

- Machine-mode CSR storage for the NPC core; the write/read end of the CSR instruction path.
- The CSR read-modify-write datapath reads the old value from this block and returns the new value on csr_wdata.
- Holds mstatus, mtvec, mepc, mcause, the mcycle/mcycleh counter and read-only ID registers.
- Performs trap entry on ecall and trap return on mret, and supplies the redirect PC to fetch.

---
 rtl/csr_defs.sv | 37 +++
 rtl/csr_mcycle_counter.sv | 51 +++++
 rtl/csr_file.sv | 124 ++++++++++++
 tb/tb_csr_file.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/csr_defs.sv
// ============================================================================
// Module : csr_defs (package)
// Brief  : CSR addresses, mstatus bit positions and cause codes for csr_file.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package csr_defs;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MVENDORID = 12'hF11;
    localparam logic [11:0] CSR_MARCHID   = 12'hF12;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;

    localparam logic [31:0] CAUSE_ECALL_M = 32'd11;

    // Only M-mode exists, so the privilege fields are pinned at 2'b11.
    function automatic logic [31:0] mstatus_pack(input logic mie, input logic mpie);
        logic [31:0] v;
        v                      = '0;
        v[MSTATUS_MIE]         = mie;
        v[MSTATUS_MPIE]        = mpie;
        v[MSTATUS_MPP_LO+1 -: 2] = 2'b11;
        return v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/csr_mcycle_counter.sv
// ============================================================================
// Module : csr_mcycle_counter
// Brief  : 64-bit free-running cycle counter with independent half writes.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module csr_mcycle_counter #(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wen_lo_i,
    input  logic              wen_hi_i,
    input  logic [XLEN-1:0]   wdata_i,
    output logic [2*XLEN-1:0] count_o
);

    logic [XLEN-1:0] lo_q, lo_d;
    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN:0]   w_lo_inc;

    assign w_lo_inc = {1'b0, lo_q} + {{XLEN{1'b0}}, 1'b1};

    // A high-half write overrides the carry; a low-half write freezes the count.
    always_comb begin
        lo_d = w_lo_inc[XLEN-1:0];
        hi_d = hi_q + {{(XLEN-1){1'b0}}, w_lo_inc[XLEN]};
        if (wen_lo_i) begin
            lo_d = wdata_i;
            hi_d = hi_q;
        end else if (wen_hi_i) begin
            hi_d = wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lo_q <= '0;
            hi_q <= '0;
        end else begin
            lo_q <= lo_d;
            hi_q <= hi_d;
        end
    end

    assign count_o = {hi_q, lo_q};

endmodule

`default_nettype wire

// File: rtl/csr_file.sv
// ============================================================================
// Module : csr_file
// Brief  : Machine-mode CSR storage, trap entry/return and redirect targets.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module csr_file
    import csr_defs::*;
#(
    parameter int          XLEN          = 32,
    parameter logic [31:0] MVENDORID_VAL = 32'h7973_7978,
    parameter logic [31:0] MARCHID_VAL   = 32'h0,
    parameter logic [31:0] MTVEC_RST     = 32'h0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [11:0]     csr_addr,
    input  logic            csr_ren,
    input  logic            csr_wen,
    input  logic [XLEN-1:0] csr_wdata,
    output logic [XLEN-1:0] csr_rdata,
    output logic            csr_illegal,
    input  logic            ecall,
    input  logic            mret,
    input  logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] trap_pc,
    output logic [XLEN-1:0] mret_pc
);

    logic            mie_q, mie_d;
    logic            mpie_q, mpie_d;
    logic [XLEN-1:0] mtvec_q, mtvec_d;
    logic [XLEN-1:0] mepc_q, mepc_d;
    logic [XLEN-1:0] mcause_q, mcause_d;

    logic              w_impl;
    logic              w_ro;
    logic              w_wr;
    logic [2*XLEN-1:0] w_mcycle;

    assign w_ro = (csr_addr[11:10] == 2'b11);
    assign w_wr = csr_wen & ~ecall & ~mret & w_impl & ~w_ro;

    always_comb begin
        w_impl    = 1'b1;
        csr_rdata = '0;
        case (csr_addr)
            CSR_MSTATUS:   csr_rdata = mstatus_pack(mie_q, mpie_q);
            CSR_MTVEC:     csr_rdata = mtvec_q;
            CSR_MEPC:      csr_rdata = mepc_q;
            CSR_MCAUSE:    csr_rdata = mcause_q;
            CSR_MCYCLE:    csr_rdata = w_mcycle[XLEN-1:0];
            CSR_MCYCLEH:   csr_rdata = w_mcycle[2*XLEN-1:XLEN];
            CSR_MVENDORID: csr_rdata = MVENDORID_VAL;
            CSR_MARCHID:   csr_rdata = MARCHID_VAL;
            default:       w_impl    = 1'b0;
        endcase
    end

    assign csr_illegal = csr_ren & (~w_impl | (csr_wen & w_ro));

    // Trap entry dominates trap return, which dominates software writes.
    always_comb begin
        mie_d    = mie_q;
        mpie_d   = mpie_q;
        mtvec_d  = mtvec_q;
        mepc_d   = mepc_q;
        mcause_d = mcause_q;
        if (ecall) begin
            mepc_d   = {pc[XLEN-1:2], 2'b00};
            mcause_d = CAUSE_ECALL_M;
            mpie_d   = mie_q;
            mie_d    = 1'b0;
        end else if (mret) begin
            mie_d  = mpie_q;
            mpie_d = 1'b1;
        end else if (w_wr) begin
            case (csr_addr)
                CSR_MSTATUS: begin
                    mie_d  = csr_wdata[MSTATUS_MIE];
                    mpie_d = csr_wdata[MSTATUS_MPIE];
                end
                CSR_MTVEC:  mtvec_d  = {csr_wdata[XLEN-1:2], 2'b00};
                CSR_MEPC:   mepc_d   = {csr_wdata[XLEN-1:2], 2'b00};
                CSR_MCAUSE: mcause_d = csr_wdata;
                default:    ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mie_q    <= 1'b0;
            mpie_q   <= 1'b0;
            mtvec_q  <= MTVEC_RST;
            mepc_q   <= '0;
            mcause_q <= '0;
        end else begin
            mie_q    <= mie_d;
            mpie_q   <= mpie_d;
            mtvec_q  <= mtvec_d;
            mepc_q   <= mepc_d;
            mcause_q <= mcause_d;
        end
    end

    csr_mcycle_counter #(
        .XLEN (XLEN)
    ) u_mcycle (
        .clk      (clk),
        .rst      (rst),
        .wen_lo_i (w_wr && (csr_addr == CSR_MCYCLE)),
        .wen_hi_i (w_wr && (csr_addr == CSR_MCYCLEH)),
        .wdata_i  (csr_wdata),
        .count_o  (w_mcycle)
    );

    assign trap_pc = {mtvec_q[XLEN-1:2], 2'b00};
    assign mret_pc = mepc_q;

endmodule

`default_nettype wire

// File: tb/tb_csr_file.sv
// ============================================================================
// Module : tb_csr_file
// Brief  : Directed bench for csr_file with a reference model and literal pins.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_csr_file;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] csr_addr;
    logic        csr_ren, csr_wen;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        csr_illegal;
    logic        ecall, mret;
    logic [31:0] pc;
    logic [31:0] trap_pc, mret_pc;

    int checks = 0;
    int errors = 0;

    always #10 clk = ~clk;

    csr_file dut (
        .clk         (clk),
        .rst         (rst),
        .csr_addr    (csr_addr),
        .csr_ren     (csr_ren),
        .csr_wen     (csr_wen),
        .csr_wdata   (csr_wdata),
        .csr_rdata   (csr_rdata),
        .csr_illegal (csr_illegal),
        .ecall       (ecall),
        .mret        (mret),
        .pc          (pc),
        .trap_pc     (trap_pc),
        .mret_pc     (mret_pc)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic        m_mie, m_mpie;
    logic [31:0] m_mtvec, m_mepc, m_mcause;
    logic [63:0] m_cycle;
    bit          m_started = 0;
    bit          m_wr;

    function automatic bit m_impl(input logic [11:0] a);
        return a == 12'h300 || a == 12'h305 || a == 12'h341 || a == 12'h342 ||
               a == 12'hB00 || a == 12'hB80 || a == 12'hF11 || a == 12'hF12;
    endfunction

    function automatic logic [31:0] m_read(input logic [11:0] a);
        case (a)
            12'h300: return 32'h1800 + (m_mie ? 32'h8 : 32'h0) + (m_mpie ? 32'h80 : 32'h0);
            12'h305: return m_mtvec;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'hB00: return m_cycle[31:0];
            12'hB80: return m_cycle[63:32];
            12'hF11: return 32'h7973_7978;
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_started = 1;
            m_mie = 0; m_mpie = 0;
            m_mtvec = 0; m_mepc = 0; m_mcause = 0;
            m_cycle = 0;
        end else if (m_started) begin
            m_wr = csr_wen && !ecall && !mret && m_impl(csr_addr) && (csr_addr < 12'hC00);
            if (m_wr && csr_addr == 12'hB00)
                m_cycle = {m_cycle[63:32], csr_wdata};
            else if (m_wr && csr_addr == 12'hB80)
                m_cycle = {csr_wdata, m_cycle[31:0] + 32'd1};
            else
                m_cycle = m_cycle + 64'd1;
            if (ecall) begin
                m_mepc = pc & ~32'h3;
                m_mcause = 32'd11;
                m_mpie = m_mie;
                m_mie = 0;
            end else if (mret) begin
                m_mie = m_mpie;
                m_mpie = 1;
            end else if (m_wr) begin
                case (csr_addr)
                    12'h300: begin m_mie = csr_wdata[3]; m_mpie = csr_wdata[7]; end
                    12'h305: m_mtvec = csr_wdata & ~32'h3;
                    12'h341: m_mepc = csr_wdata & ~32'h3;
                    12'h342: m_mcause = csr_wdata;
                    default: ;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (m_started) begin
            check("cmp_rdata", csr_rdata, m_read(csr_addr));
            check("cmp_illegal", {31'b0, csr_illegal},
                  {31'b0, csr_ren && (!m_impl(csr_addr) || (csr_wen && csr_addr >= 12'hC00))});
            check("cmp_trap_pc", trap_pc, m_mtvec & ~32'h3);
            check("cmp_mret_pc", mret_pc, m_mepc);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic rdchk(input string name, input logic [11:0] a, input logic [31:0] exp);
        csr_addr = a;
        #1;
        check(name, csr_rdata, exp);
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        csr_addr  = a;
        csr_wen   = 1'b1;
        csr_wdata = d;
        cyc();
        csr_wen = 1'b0;
    endtask

    initial begin
        rst = 1'b1; csr_addr = 12'h0; csr_ren = 1'b1; csr_wen = 1'b0;
        csr_wdata = 32'h0; ecall = 1'b0; mret = 1'b0; pc = 32'h0;
        cyc(); cyc();
        rst = 1'b0;

        rdchk("rst_mstatus", 12'h300, 32'h0000_1800);
        rdchk("rst_mtvec", 12'h305, 32'h0);
        rdchk("rst_mepc", 12'h341, 32'h0);
        rdchk("rst_mcause", 12'h342, 32'h0);
        rdchk("rst_mvendorid", 12'hF11, 32'h7973_7978);
        rdchk("rst_mcycle0", 12'hB00, 32'd0);
        cyc(); rdchk("rst_mcycle1", 12'hB00, 32'd1);
        cyc(); rdchk("rst_mcycle2", 12'hB00, 32'd2);
        cyc(); rdchk("rst_mcycle3", 12'hB00, 32'd3);

        wr(12'h305, 32'h8000_0007); rdchk("mask_mtvec", 12'h305, 32'h8000_0004);
        wr(12'h300, 32'hFFFF_FFFF); rdchk("mask_mstatus_ones", 12'h300, 32'h0000_1888);
        wr(12'h300, 32'h0);         rdchk("mask_mstatus_zero", 12'h300, 32'h0000_1800);
        wr(12'h341, 32'h1234_567B); rdchk("mask_mepc", 12'h341, 32'h1234_5678);

        // trap entry
        wr(12'h305, 32'h8000_0100);
        wr(12'h300, 32'h0000_0008);
        pc = 32'h8000_0040; ecall = 1'b1;
        #1 check("ecall_trap_pc", trap_pc, 32'h8000_0100);
        cyc(); ecall = 1'b0;
        rdchk("ecall_mepc", 12'h341, 32'h8000_0040);
        rdchk("ecall_mcause", 12'h342, 32'd11);
        rdchk("ecall_mstatus", 12'h300, 32'h0000_1880);

        // trap return
        mret = 1'b1;
        #1 check("mret_pc", mret_pc, 32'h8000_0040);
        cyc(); mret = 1'b0;
        rdchk("mret_mstatus", 12'h300, 32'h0000_1888);

        // ecall + mret + write together: only the ecall lands
        pc = 32'h8000_0120; ecall = 1'b1; mret = 1'b1;
        csr_addr = 12'h341; csr_wen = 1'b1; csr_wdata = 32'hDEAD_BEEC;
        cyc(); ecall = 1'b0; mret = 1'b0; csr_wen = 1'b0;
        rdchk("simul_mepc", 12'h341, 32'h8000_0120);
        rdchk("simul_mstatus", 12'h300, 32'h0000_1880);

        // write to a read-only CSR
        csr_addr = 12'hF12; csr_wen = 1'b1; csr_wdata = 32'h1234_5678;
        #1 check("ro_write_illegal", {31'b0, csr_illegal}, 32'd1);
        cyc(); csr_wen = 1'b0;
        rdchk("ro_write_dropped", 12'hF12, 32'h0);
        check("ro_read_legal", {31'b0, csr_illegal}, 32'd0);

        // unimplemented address
        rdchk("unimpl_rdata", 12'h7C0, 32'h0);
        check("unimpl_illegal", {31'b0, csr_illegal}, 32'd1);
        csr_ren = 1'b0; #1;
        check("unimpl_no_ren", {31'b0, csr_illegal}, 32'd0);
        csr_ren = 1'b1;
        cyc();

        // mcycle boundaries
        wr(12'hB80, 32'h0);
        wr(12'hB00, 32'hFFFF_FFFF);
        rdchk("cyc_lo_written", 12'hB00, 32'hFFFF_FFFF);
        rdchk("cyc_hi_before", 12'hB80, 32'h0);
        cyc();
        rdchk("cyc_hi_carry", 12'hB80, 32'h1);
        rdchk("cyc_lo_wrapped", 12'hB00, 32'h0);
        wr(12'hB00, 32'hFFFF_FFFF);
        wr(12'hB80, 32'd5);
        rdchk("cyc_hi_write", 12'hB80, 32'd5);
        rdchk("cyc_hi_write_lo", 12'hB00, 32'd0);
        wr(12'hB00, 32'd10);
        rdchk("cyc_lo_write", 12'hB00, 32'd10);
        cyc(); rdchk("cyc_lo_next", 12'hB00, 32'd11);
        wr(12'hB80, 32'hFFFF_FFFF);
        wr(12'hB00, 32'hFFFF_FFFE);
        cyc(); cyc();
        rdchk("cyc_wrap_hi", 12'hB80, 32'h0);
        rdchk("cyc_wrap_lo", 12'hB00, 32'h0);

        // reset during a trap discards it
        rst = 1'b1; ecall = 1'b1; pc = 32'h8000_0200;
        cyc(); rst = 1'b0; ecall = 1'b0;
        rdchk("rst_trap_mepc", 12'h341, 32'h0);
        rdchk("rst_trap_mcause", 12'h342, 32'h0);
        rdchk("rst_trap_mstatus", 12'h300, 32'h0000_1800);
        cyc(); cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
